radix_4: RTL and testbench
==========================

RADIX_4 -- requirements
Module: radix_4

Interface
REQ-001 Parameter: N, default 8, operand width in bits; N SHALL be even and >= 4.
REQ-002 Port: clock  input  1  sole clock; all state changes on its rising edge.
REQ-003 Port: reset  input  1  one clock; reset is asynchronous and active-low.
REQ-004 Port: start  input  1  request to begin a multiplication; level-sampled on rising clock edges.
REQ-005 Port: x  input  N  multiplicand, signed two's complement.
REQ-006 Port: y  input  N  multiplier, signed two's complement.
REQ-007 Port: result  output  2N  signed product x*y, registered.
REQ-008 Port: ready  output  1  high when result holds a completed product.
REQ-009 Port order SHALL be clock, reset, start, x, y, result, ready.

Function
REQ-010 The block SHALL compute the exact signed 2N-bit product x*y using radix-4 (modified Booth) recoding of y.
REQ-011 Recoding: append y[-1]=0; for i=0..N/2-1, triplet y[2i+1:2i-1] SHALL map to a digit: 000/111->0, 001/010->+1, 011->+2, 100->-2, 101/110->-1.
REQ-012 Partial product i SHALL be digit*x, sign-extended to 2N+2 bits, weighted by 4^i; the accumulator SHALL be at least 2N+2 bits wide, and result SHALL be its low 2N bits.
REQ-013 The FSM SHALL have exactly three states: IDLE, CALC, DONE.
REQ-014 IDLE: ready=0; if start=1 at an edge, the block SHALL latch x and y, clear the accumulator and step counter, and go to CALC.
REQ-015 CALC: one Booth digit SHALL be processed per cycle, for N/2 cycles (4 for N=8); after the last digit, the FSM SHALL go to DONE.
REQ-016 Latency: if start is sampled high at edge k, the updated result and ready=1 SHALL be visible after edge k+N/2+1 (k+5 for N=8).
REQ-017 DONE: ready=1 and result SHALL be held stable; if start=0, remain in DONE.
REQ-018 DONE with start=1: ready SHALL drop, new x and y SHALL be latched, and the FSM SHALL go to CALC; this makes back-to-back operations possible.
REQ-019 start during CALC SHALL be ignored; changes to x and y after latching SHALL NOT affect the running operation.
REQ-020 result SHALL keep its previous value during CALC and update only on entry to DONE.
REQ-021 Extreme operands (x or y = -2^(N-1)) SHALL produce exact products without overflow (e.g. -128*-128=16384).

Reset
REQ-022 reset=0 SHALL immediately, independent of clock, force state=IDLE, ready=0, result=0, and clear the accumulator, counter and operand registers.
REQ-023 Reset asserted during CALC or DONE SHALL abort the operation; after release the block SHALL wait in IDLE for start.
REQ-024 After release, the first rising edge with start=1 SHALL be accepted normally.

Structure
REQ-025 A shared package radix_4_pkg SHALL hold the state enum (IDLE, CALC, DONE), the default width constant, and the Booth-digit encoding type.
REQ-026 One sub-module, booth_encoder, SHALL map a 3-bit triplet to a digit (neg, zero, two flags); all other logic stays in radix_4.

Verification
REQ-027 Reset low 1 cycle, then x=21, y=37, start high 3 cycles -> ready rises 5 cycles after start is first sampled, result=777, ready stays high.
REQ-028 x=-128, y=-128 -> result=16384; x=-128, y=127 -> result=-16256 (0xC080).
REQ-029 x=0, y=-1 -> result=0; x=-1, y=-1 -> result=1; x=127, y=127 -> result=16129.
REQ-030 reset pulsed low 2 cycles into CALC -> ready=0 and result=0 immediately; a new start then yields the correct product.
REQ-031 In DONE, start=1 with x=3, y=-5 -> ready drops next cycle, rises 5 cycles later with result=-15; x/y changes during CALC do not alter it.
REQ-032 Random signed 8-bit operands (>=1000) compared against a reference multiply -> zero mismatches.

Source files
------------

// File: rtl/radix_4_pkg.sv
// Shared types for the radix-4 Booth multiplier: FSM states, default width,
// and the Booth digit encoding produced by booth_encoder.
package radix_4_pkg;

  localparam int DEFAULT_N = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // Digit magnitude is 0, 1 or 2; neg selects the sign.
  typedef struct packed {
    logic neg;
    logic zero;
    logic two;
  } booth_digit_t;

endpackage

// File: rtl/radix_4_booth_encoder.sv
// Maps a Booth triplet y[2i+1:2i-1] to a signed digit in {-2,-1,0,+1,+2}.
module booth_encoder
  import radix_4_pkg::*;
(
  input  logic [2:0]   i_triplet,
  output booth_digit_t o_digit
);

  always_comb begin
    o_digit.zero = (i_triplet == 3'b000) || (i_triplet == 3'b111);
    o_digit.two  = (i_triplet == 3'b011) || (i_triplet == 3'b100);
    o_digit.neg  = i_triplet[2] && !(i_triplet[1] && i_triplet[0]);
  end

endmodule

// File: rtl/radix_4.sv
// Sequential signed multiplier: one radix-4 Booth digit per cycle,
// result registered on entry to DONE.
module radix_4
  import radix_4_pkg::*;
#(
  parameter int N = DEFAULT_N
)
(
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [N-1:0]     x,
  input  logic [N-1:0]     y,
  output logic [2*N-1:0]   result,
  output logic             ready
);

  localparam int AW = 2*N + 2;
  localparam int CW = $clog2(N/2 + 1);
  localparam logic [CW-1:0] LAST = CW'(N/2);

  state_t         r_state;
  state_t         w_state_nxt;
  logic [AW-1:0]  r_acc;
  logic [AW-1:0]  r_mcand;
  logic [N:0]     r_ybits;
  logic [CW-1:0]  r_cnt;
  logic [2*N-1:0] r_result;
  logic [AW-1:0]  w_pp_mag;
  logic [AW-1:0]  w_pp;
  booth_digit_t   w_digit;
  logic           w_load;
  logic           w_step;
  logic           w_finish;

  booth_encoder u_booth_encoder (
    .i_triplet (r_ybits[2:0]),
    .o_digit   (w_digit)
  );

  // r_mcand is pre-shifted by 4^i, so the partial product is just x, 2x or 0.
  always_comb begin
    w_pp_mag = w_digit.two ? {r_mcand[AW-2:0], 1'b0} : r_mcand;
    if (w_digit.zero)
      w_pp = '0;
    else if (w_digit.neg)
      w_pp = '0 - w_pp_mag;
    else
      w_pp = w_pp_mag;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_step      = 1'b0;
    w_finish    = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_load      = 1'b1;
          w_state_nxt = CALC;
        end
      end
      CALC: begin
        if (r_cnt == LAST) begin
          w_finish    = 1'b1;
          w_state_nxt = DONE;
        end else begin
          w_step = 1'b1;
        end
      end
      DONE: begin
        if (start) begin
          w_load      = 1'b1;
          w_state_nxt = CALC;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state  <= IDLE;
      r_acc    <= '0;
      r_mcand  <= '0;
      r_ybits  <= '0;
      r_cnt    <= '0;
      r_result <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_load) begin
        r_mcand <= {{(N+2){x[N-1]}}, x};
        r_ybits <= {y, 1'b0};
        r_acc   <= '0;
        r_cnt   <= '0;
      end else if (w_step) begin
        r_acc   <= r_acc + w_pp;
        r_mcand <= {r_mcand[AW-3:0], 2'b00};
        r_ybits <= {2'b00, r_ybits[N:2]};
        r_cnt   <= r_cnt + CW'(1);
      end
      if (w_finish)
        r_result <= r_acc[2*N-1:0];
    end
  end

  assign result = r_result;
  assign ready  = (r_state == DONE);

endmodule

// File: tb/tb_radix_4.sv
// Scoreboard bench for radix_4: stimulus queues expected product and arrival
// cycle; a negedge monitor checks each rising edge of ready.
module tb_radix_4;

  logic               clock = 1'b0;
  logic               reset = 1'b0;
  logic               start = 1'b0;
  logic signed [7:0]  x = '0;
  logic signed [7:0]  y = '0;
  logic [15:0]        result;
  logic               ready;

  typedef struct {
    logic signed [15:0] res;
    int                 cyc;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  logic prev_ready = 1'b0;

  radix_4 #(.N(8)) dut (
    .clock  (clock),
    .reset  (reset),
    .start  (start),
    .x      (x),
    .y      (y),
    .result (result),
    .ready  (ready)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string nm, input logic signed [31:0] act, input logic signed [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(negedge clock) begin
    exp_t e;
    if (ready === 1'b1 && prev_ready !== 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_ready", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("product", $signed(result), e.res);
        check("latency", cyc, e.cyc);
      end
    end
    prev_ready = ready;
  end

  task automatic wait_done();
    int t = 0;
    while (exp_q.size() != 0 && t < 30) begin
      @(negedge clock);
      #1;
      t++;
    end
    if (exp_q.size() != 0) begin
      check("timeout_ready", 0, 1);
      exp_q.delete();
    end
  endtask

  // One-cycle start pulse; operands are scrambled once latched.
  task automatic op(input logic signed [7:0] a, input logic signed [7:0] b,
                    input logic signed [15:0] e);
    @(negedge clock);
    x = a; y = b; start = 1'b1;
    exp_q.push_back('{e, cyc + 6});
    @(negedge clock);
    start = 1'b0; x = ~a; y = ~b;
    wait_done();
  endtask

  initial begin
    logic signed [7:0]  ra;
    logic signed [7:0]  rb;
    logic signed [15:0] re;

    @(negedge clock);
    check("reset_ready", ready, 0);
    check("reset_result", $signed(result), 0);
    reset = 1'b1;

    // start held for three sampled edges; only the first is accepted
    @(negedge clock);
    x = 8'sd21; y = 8'sd37; start = 1'b1;
    exp_q.push_back('{16'sd777, cyc + 6});
    repeat (3) @(negedge clock);
    start = 1'b0;
    wait_done();
    repeat (3) begin
      @(negedge clock);
      check("hold_ready", ready, 1);
      check("hold_result", $signed(result), 777);
    end

    op(-8'sd128, -8'sd128, 16'sd16384);
    op(-8'sd128,  8'sd127, -16'sd16256);
    op( 8'sd0,   -8'sd1,   16'sd0);
    op(-8'sd1,   -8'sd1,   16'sd1);
    op( 8'sd127,  8'sd127, 16'sd16129);

    // back-to-back from DONE with operand changes during CALC
    @(negedge clock);
    x = 8'sd3; y = -8'sd5; start = 1'b1;
    exp_q.push_back('{-16'sd15, cyc + 6});
    @(negedge clock);
    start = 1'b0; x = 8'sd100; y = -8'sd77;
    check("ready_drop", ready, 0);
    @(negedge clock);
    x = -8'sd128; y = 8'sd55; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    wait_done();

    // asynchronous reset two cycles into CALC
    @(negedge clock);
    x = 8'sd50; y = 8'sd60; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    @(negedge clock);
    #2;
    reset = 1'b0;
    #1;
    check("abort_ready", ready, 0);
    check("abort_result", $signed(result), 0);
    @(negedge clock);
    reset = 1'b1;
    repeat (6) begin
      @(negedge clock);
      check("idle_after_abort", ready, 0);
    end
    op(8'sd50, 8'sd60, 16'sd3000);

    for (int i = 0; i < 1000; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      re = 16'(ra * rb);
      op(ra, rb, re);
    end

    repeat (3) @(negedge clock);
    check("queue_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
